scan_decoder: RTL and testbench

- Parametrised, registered one-hot decoder: SEL_W-bit index to OUTS = 2^SEL_W active-high outputs, with enable.
- Successor to the combinational 4-to-16 enable-gated decoder. Adds registered outputs, an auto-scan mode, a one-shot sweep mode and a hold mode.
- Drives row/channel strobes: selects one channel at a time, either directly or by stepping through channels autonomously with a programmable dwell.

---
 rtl/scan_decoder.sv | 172 +++++++++++++++++
 tb/tb_scan_decoder.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/scan_decoder.sv
// rtl/scan_decoder.sv - registered one-hot channel decoder with direct, scan, sweep and hold modes
//
// Ports:
//   clk   in   rising-edge clock
//   rst   in   synchronous active-high reset
//   w     in   [SEL_W-1:0] direct index / scan or sweep start index
//   e     in   enable; low forces y to zero and pauses stepping
//   mode  in   [1:0] 00 direct, 01 scan, 10 one-shot sweep, 11 hold
//   load  in   one-cycle strobe; in scan/sweep loads idx from w and restarts dwell
//   y     out  [0:OUTS-1] registered one-hot strobes, y[0] is channel 0
//   idx   out  [SEL_W-1:0] current registered channel index
//   busy  out  high while a sweep is running
//   wrap  out  one-cycle pulse when a scan steps from OUTS-1 to 0
//   done  out  one-cycle pulse when a sweep completes
module scan_decoder #(
    parameter int SEL_W = 4,
    parameter int DWELL = 3,
    parameter int DW_W  = 8,
    localparam int OUTS = 1 << SEL_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SEL_W-1:0] w,
    input  logic             e,
    input  logic [1:0]       mode,
    input  logic             load,
    output logic [0:OUTS-1]  y,
    output logic [SEL_W-1:0] idx,
    output logic             busy,
    output logic             wrap,
    output logic             done
);

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    localparam logic [1:0]       M_DIRECT   = 2'b00;
    localparam logic [1:0]       M_SCAN     = 2'b01;
    localparam logic [1:0]       M_HOLD     = 2'b11;
    localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(DWELL - 1);
    localparam logic [SEL_W-1:0] IDX_LAST   = '1;

    state_t           state_q, state_d;
    logic [SEL_W-1:0] idx_q, idx_d;
    logic [DW_W-1:0]  dwell_q, dwell_d;
    logic [0:OUTS-1]  y_q, y_d;
    logic             busy_q, busy_d;
    logic             wrap_q, wrap_d;
    logic             done_q, done_d;
    // Last non-hold mode seen; hold excursions leave it untouched so that
    // returning to the same mode resumes rather than counting as a change.
    logic [1:0]       mode_q, mode_d;

    logic             mode_chg;
    logic [SEL_W-1:0] step_idx;
    logic [DW_W-1:0]  step_dwell;
    logic             step_wrap;
    logic             sweep_end;

    function automatic logic [0:OUTS-1] onehot(input logic [SEL_W-1:0] k);
        logic [0:OUTS-1] v;
        v    = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    // One enabled dwell step shared by scan and sweep.
    always_comb begin
        step_idx   = idx_q;
        step_dwell = dwell_q + DW_W'(1);
        step_wrap  = 1'b0;
        if (dwell_q == DWELL_LAST) begin
            step_idx   = idx_q + SEL_W'(1);
            step_dwell = '0;
            step_wrap  = (idx_q == IDX_LAST);
        end
    end

    assign mode_chg  = (mode != M_HOLD) && (mode != mode_q);
    assign sweep_end = (idx_q == IDX_LAST) && (dwell_q == DWELL_LAST);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        dwell_d = dwell_q;
        y_d     = y_q;
        busy_d  = busy_q;
        wrap_d  = 1'b0;
        done_d  = 1'b0;
        mode_d  = mode_q;

        if (mode == M_HOLD) begin
            // everything frozen; pulses already defaulted low
        end else if (mode_chg) begin
            // Mode change outranks load and stepping; idx is kept, y blanked.
            mode_d  = mode;
            dwell_d = '0;
            state_d = S_IDLE;
            busy_d  = 1'b0;
            y_d     = '0;
        end else if (mode == M_DIRECT) begin
            idx_d   = w;
            dwell_d = '0;
            y_d     = e ? onehot(w) : '0;
        end else if (mode == M_SCAN) begin
            if (load) begin
                idx_d   = w;
                dwell_d = '0;
            end else if (e) begin
                idx_d   = step_idx;
                dwell_d = step_dwell;
                wrap_d  = step_wrap;
            end
            y_d = e ? onehot(idx_d) : '0;
        end else begin
            if (load) begin
                idx_d   = w;
                dwell_d = '0;
                state_d = S_RUN;
                busy_d  = 1'b1;
                y_d     = e ? onehot(w) : '0;
            end else if (state_q == S_RUN && e) begin
                if (sweep_end) begin
                    // idx stays on the last channel; no wrap in sweep
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    dwell_d = '0;
                    y_d     = '0;
                end else begin
                    idx_d   = step_idx;
                    dwell_d = step_dwell;
                    y_d     = onehot(step_idx);
                end
            end else begin
                y_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            dwell_q <= '0;
            y_q     <= '0;
            busy_q  <= 1'b0;
            wrap_q  <= 1'b0;
            done_q  <= 1'b0;
            // Adopt the applied mode so the first edge after reset is not a mode change.
            mode_q  <= mode;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            dwell_q <= dwell_d;
            y_q     <= y_d;
            busy_q  <= busy_d;
            wrap_q  <= wrap_d;
            done_q  <= done_d;
            mode_q  <= mode_d;
        end
    end

    assign y    = y_q;
    assign idx  = idx_q;
    assign busy = busy_q;
    assign wrap = wrap_q;
    assign done = done_q;

endmodule

// File: tb/tb_scan_decoder.sv
// tb/tb_scan_decoder.sv - self-checking bench for scan_decoder (DWELL=3 and DWELL=1 instances)
module tb_scan_decoder;

    localparam int OUTS = 16;

    logic        clk;
    logic        rst;
    logic [3:0]  w;
    logic        e;
    logic [1:0]  mode;
    logic        load;

    logic [15:0] y0, y1;
    logic [3:0]  idx0, idx1;
    logic        busy0, busy1, wrap0, wrap1, done0, done1;

    int errors = 0;
    int checks = 0;

    scan_decoder #(.SEL_W(4), .DWELL(3), .DW_W(8)) u_dut (
        .clk(clk), .rst(rst), .w(w), .e(e), .mode(mode), .load(load),
        .y(y0), .idx(idx0), .busy(busy0), .wrap(wrap0), .done(done0)
    );

    scan_decoder #(.SEL_W(4), .DWELL(1), .DW_W(8)) u_dut1 (
        .clk(clk), .rst(rst), .w(w), .e(e), .mode(mode), .load(load),
        .y(y1), .idx(idx1), .busy(busy1), .wrap(wrap1), .done(done1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        r;
        logic [1:0]  m;
        logic        en;
        logic        ld;
        logic [3:0]  wi;
        logic [15:0] ey;
        logic [3:0]  ei;
        logic        eb;
        logic        ew;
        logic        ed;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic [1:0] m, logic en, logic ld, logic [3:0] wi,
                                logic [15:0] ey, logic [3:0] ei, logic eb, logic ew, logic ed);
        vec_t v;
        v.r = r; v.m = m; v.en = en; v.ld = ld; v.wi = wi;
        v.ey = ey; v.ei = ei; v.eb = eb; v.ew = ew; v.ed = ed;
        return v;
    endfunction

    function automatic logic [15:0] ch(int k);
        logic [15:0] top;
        top = 16'h8000;
        return (k < 0) ? 16'h0000 : (top >> k);
    endfunction

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(logic r, logic [1:0] m, logic en, logic ld, logic [3:0] wi);
        rst = r; mode = m; e = en; load = ld; w = wi;
    endtask

    // Reference model: a channel position is a linear count pos = channel*dwell + elapsed,
    // so stepping is pos+1 and the channel is pos/dwell.
    int dw[2] = '{3, 1};
    int m_pos[2];
    bit m_run[2];
    int m_yk[2];
    bit m_wr[2];
    bit m_dn[2];

    task automatic model_step(int k, logic r, logic [1:0] m, logic en, logic ld, logic [3:0] wi);
        int span;
        span = OUTS * dw[k];
        m_wr[k] = 1'b0;
        m_dn[k] = 1'b0;
        if (r) begin
            m_pos[k] = 0; m_run[k] = 1'b0; m_yk[k] = -1;
        end else begin
            case (m)
                2'b00: begin
                    m_pos[k] = int'(wi) * dw[k];
                    m_yk[k]  = en ? int'(wi) : -1;
                end
                2'b01: begin
                    if (ld) m_pos[k] = int'(wi) * dw[k];
                    else if (en) begin
                        m_pos[k] = (m_pos[k] + 1) % span;
                        m_wr[k]  = (m_pos[k] == 0);
                    end
                    m_yk[k] = en ? m_pos[k] / dw[k] : -1;
                end
                2'b10: begin
                    if (ld) begin
                        m_pos[k] = int'(wi) * dw[k];
                        m_run[k] = 1'b1;
                        m_yk[k]  = en ? int'(wi) : -1;
                    end else if (m_run[k] && en) begin
                        if (m_pos[k] + 1 == span) begin
                            m_run[k] = 1'b0; m_dn[k] = 1'b1; m_yk[k] = -1;
                        end else begin
                            m_pos[k]++;
                            m_yk[k] = m_pos[k] / dw[k];
                        end
                    end else m_yk[k] = -1;
                end
                default: ;
            endcase
        end
    endtask

    initial begin
        drive(1'b1, 2'b00, 1'b0, 1'b0, 4'd0);

        // Directed table: reset/direct, scan wrap, full sweep.
        vecs.push_back(mk(1, 2'b00, 1, 0, 4'd5,  16'h0000, 4'd0,  0, 0, 0));
        vecs.push_back(mk(0, 2'b00, 1, 0, 4'd5,  16'h0400, 4'd5,  0, 0, 0));
        vecs.push_back(mk(0, 2'b00, 0, 0, 4'd5,  16'h0000, 4'd5,  0, 0, 0));
        vecs.push_back(mk(1, 2'b01, 1, 0, 4'd0,  16'h0000, 4'd0,  0, 0, 0));
        vecs.push_back(mk(0, 2'b01, 1, 1, 4'd14, 16'h0002, 4'd14, 0, 0, 0));
        vecs.push_back(mk(0, 2'b01, 1, 0, 4'd3,  16'h0002, 4'd14, 0, 0, 0));
        vecs.push_back(mk(0, 2'b01, 1, 0, 4'd3,  16'h0002, 4'd14, 0, 0, 0));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(0, 2'b01, 1, 0, 4'd3, 16'h0001, 4'd15, 0, 0, 0));
        vecs.push_back(mk(0, 2'b01, 1, 0, 4'd3,  16'h8000, 4'd0,  0, 1, 0));
        vecs.push_back(mk(0, 2'b01, 1, 0, 4'd3,  16'h8000, 4'd0,  0, 0, 0));
        vecs.push_back(mk(1, 2'b10, 1, 0, 4'd0,  16'h0000, 4'd0,  0, 0, 0));
        vecs.push_back(mk(0, 2'b10, 1, 1, 4'd13, 16'h0004, 4'd13, 1, 0, 0));
        for (int i = 0; i < 2; i++)
            vecs.push_back(mk(0, 2'b10, 1, 0, 4'd0, 16'h0004, 4'd13, 1, 0, 0));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(0, 2'b10, 1, 0, 4'd0, 16'h0002, 4'd14, 1, 0, 0));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(0, 2'b10, 1, 0, 4'd0, 16'h0001, 4'd15, 1, 0, 0));
        vecs.push_back(mk(0, 2'b10, 1, 0, 4'd0,  16'h0000, 4'd15, 0, 0, 1));
        vecs.push_back(mk(0, 2'b10, 1, 0, 4'd0,  16'h0000, 4'd15, 0, 0, 0));

        foreach (vecs[i]) begin
            drive(vecs[i].r, vecs[i].m, vecs[i].en, vecs[i].ld, vecs[i].wi);
            step();
            chk($sformatf("tbl%0d_y", i),    32'(y0),    32'(vecs[i].ey));
            chk($sformatf("tbl%0d_idx", i),  32'(idx0),  32'(vecs[i].ei));
            chk($sformatf("tbl%0d_busy", i), 32'(busy0), 32'(vecs[i].eb));
            chk($sformatf("tbl%0d_wrap", i), 32'(wrap0), 32'(vecs[i].ew));
            chk($sformatf("tbl%0d_done", i), 32'(done0), 32'(vecs[i].ed));
        end

        // Scan pause mid-dwell.
        drive(1, 2'b01, 1, 0, 4'd0); step();
        drive(0, 2'b01, 1, 1, 4'd3); step();
        drive(0, 2'b01, 1, 0, 4'd0); step();
        chk("pause_pre_idx", 32'(idx0), 32'd3);
        for (int i = 0; i < 4; i++) begin
            drive(0, 2'b01, 0, 0, 4'd9); step();
            chk($sformatf("pause%0d_y", i), 32'(y0), 32'h0);
            chk($sformatf("pause%0d_idx", i), 32'(idx0), 32'd3);
        end
        drive(0, 2'b01, 1, 0, 4'd0); step();
        chk("resume1_y", 32'(y0), 32'h1000);
        step();
        chk("resume2_idx", 32'(idx0), 32'd4);
        chk("resume2_y", 32'(y0), 32'h0800);

        // Sweep restart, then reset mid-sweep.
        drive(1, 2'b10, 1, 0, 4'd0); step();
        drive(0, 2'b10, 1, 1, 4'd8); step();
        drive(0, 2'b10, 1, 0, 4'd0);
        for (int i = 0; i < 6; i++) step();
        chk("restart_pre_idx", 32'(idx0), 32'd10);
        drive(0, 2'b10, 1, 1, 4'd2); step();
        chk("restart_idx", 32'(idx0), 32'd2);
        chk("restart_busy", 32'(busy0), 32'd1);
        chk("restart_done", 32'(done0), 32'd0);
        drive(0, 2'b10, 1, 0, 4'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("restart_run%0d", i), 32'({busy0, done0}), 32'b10);
        end
        drive(1, 2'b10, 1, 0, 4'd0); step();
        chk("midrst_state", 32'({y0, idx0, busy0, done0}), 32'h0);
        drive(0, 2'b10, 1, 0, 4'd0); step();
        chk("postrst_state", 32'({y0, busy0, done0}), 32'h0);

        // Hold freezes scan mid-dwell, then resumes.
        drive(1, 2'b01, 1, 0, 4'd0); step();
        drive(0, 2'b01, 1, 1, 4'd7); step();
        drive(0, 2'b01, 1, 0, 4'd0); step(); step();
        chk("hold_pre_idx", 32'(idx0), 32'd7);
        for (int i = 0; i < 5; i++) begin
            drive(0, 2'b11, 1'(i), 1'(i + 1), 4'(i * 3)); step();
            chk($sformatf("hold%0d_y", i), 32'(y0), 32'h0100);
            chk($sformatf("hold%0d_idx", i), 32'(idx0), 32'd7);
            chk($sformatf("hold%0d_pulse", i), 32'({wrap0, done0}), 32'h0);
        end
        drive(0, 2'b01, 1, 0, 4'd0); step();
        chk("unhold_idx", 32'(idx0), 32'd8);
        chk("unhold_y", 32'(y0), 32'h0080);

        // Randomised segments against the model, both dwell settings.
        for (int seg = 0; seg < 9; seg++) begin
            logic [1:0] sm;
            int hold_left;
            sm = 2'(seg % 3);
            hold_left = 0;
            drive(1, sm, 1, 0, 4'd0);
            for (int k = 0; k < 2; k++) model_step(k, 1, sm, 1, 0, 4'd0);
            step();
            for (int c = 0; c < 60; c++) begin
                logic [1:0] m;
                logic en, ld;
                logic [3:0] wi;
                if (hold_left == 0 && sm != 2'b00 && $urandom_range(0, 19) == 0)
                    hold_left = int'($urandom_range(1, 4));
                m = sm;
                if (hold_left > 0) begin
                    m = 2'b11;
                    hold_left--;
                end
                en = ($urandom_range(0, 99) < 85);
                ld = (sm == 2'b10) ? ($urandom_range(0, 24) == 0) : ($urandom_range(0, 7) == 0);
                wi = 4'($urandom_range(0, 15));
                drive(0, m, en, ld, wi);
                for (int k = 0; k < 2; k++) model_step(k, 0, m, en, ld, wi);
                step();
                chk($sformatf("rnd s%0d c%0d d3 y", seg, c), 32'(y0), 32'(ch(m_yk[0])));
                chk($sformatf("rnd s%0d c%0d d3 idx/busy/wrap/done", seg, c),
                    32'({idx0, busy0, wrap0, done0}),
                    32'({4'(m_pos[0] / dw[0]), m_run[0], m_wr[0], m_dn[0]}));
                chk($sformatf("rnd s%0d c%0d d1 y", seg, c), 32'(y1), 32'(ch(m_yk[1])));
                chk($sformatf("rnd s%0d c%0d d1 idx/busy/wrap/done", seg, c),
                    32'({idx1, busy1, wrap1, done1}),
                    32'({4'(m_pos[1] / dw[1]), m_run[1], m_wr[1], m_dn[1]}));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
